// File: rtl/alarm_zones_ctrl.sv
// rtl/alarm_zones_ctrl.sv - multi-zone intrusion alarm controller
// Exit/entry delays, timed siren, latched trip memory; all outputs registered.
module alarm_zones_ctrl #(
  parameter int N_ZONES    = 4,
  parameter int EXIT_DLY   = 16,
  parameter int ENTRY_DLY  = 8,
  parameter int SIREN_TIME = 32,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inArm,
  input  logic               inDisarm,
  input  logic [N_ZONES-1:0] inZone,
  input  logic [N_ZONES-1:0] inDelayed,
  input  logic [N_ZONES-1:0] inBypass,
  output logic [2:0]         state,
  output logic               armed,
  output logic               siren,
  output logic               beep,
  output logic               arm_fault,
  output logic [CNT_W-1:0]   countdown,
  output logic [N_ZONES-1:0] tripped
);

  typedef enum logic [2:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] L_EXIT  = CNT_W'(EXIT_DLY - 1);
  localparam logic [CNT_W-1:0] L_ENTRY = CNT_W'(ENTRY_DLY - 1);
  localparam logic [CNT_W-1:0] L_SIREN = CNT_W'(SIREN_TIME - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_ZONES-1:0] r_trip;
  logic               r_fault;
  logic               r_armed;
  logic               r_siren;
  logic               r_beep;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_dec;
  logic [N_ZONES-1:0] w_trip_nxt;
  logic [N_ZONES-1:0] w_act;
  logic               w_fault_nxt;
  logic               w_inst;
  logic               w_dly;

  assign w_act  = inZone & ~inBypass;
  assign w_inst = |(w_act & ~inDelayed);
  assign w_dly  = |(w_act & inDelayed);
  // Saturating decrement: the timer must never wrap below zero.
  assign w_cnt_dec = (r_cnt != '0) ? r_cnt - 1'b1 : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_trip_nxt  = r_trip;
    w_fault_nxt = 1'b0;
    if (inDisarm) begin
      w_state_nxt = ST_DISARMED;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_DISARMED: begin
          w_cnt_nxt = '0;
          if (inArm) begin
            if (w_act == '0) begin
              w_state_nxt = ST_EXIT_DELAY;
              w_cnt_nxt   = L_EXIT;
              w_trip_nxt  = '0;
            end else begin
              w_fault_nxt = 1'b1;
            end
          end
        end
        ST_EXIT_DELAY: begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_ARMED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_dec;
          end
        end
        ST_ARMED: begin
          w_trip_nxt = r_trip | w_act;
          w_cnt_nxt  = '0;
          if (w_inst) begin
            w_state_nxt = ST_ALARM;
            w_cnt_nxt   = L_SIREN;
          end else if (w_dly) begin
            w_state_nxt = ST_ENTRY_DELAY;
            w_cnt_nxt   = L_ENTRY;
          end
        end
        ST_ENTRY_DELAY: begin
          w_trip_nxt = r_trip | w_act;
          if (w_inst || (r_cnt == '0)) begin
            w_state_nxt = ST_ALARM;
            w_cnt_nxt   = L_SIREN;
          end else begin
            w_cnt_nxt = w_cnt_dec;
          end
        end
        ST_ALARM: begin
          w_trip_nxt = r_trip | w_act;
          if (r_cnt == '0) begin
            w_state_nxt = ST_ARMED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_dec;
          end
        end
        default: begin
          w_state_nxt = ST_DISARMED;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Flag outputs are decoded from the next state so they line up with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_DISARMED;
      r_cnt   <= '0;
      r_trip  <= '0;
      r_fault <= 1'b0;
      r_armed <= 1'b0;
      r_siren <= 1'b0;
      r_beep  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_trip  <= w_trip_nxt;
      r_fault <= w_fault_nxt;
      r_armed <= (w_state_nxt == ST_ARMED) || (w_state_nxt == ST_ENTRY_DELAY) ||
                 (w_state_nxt == ST_ALARM);
      r_siren <= (w_state_nxt == ST_ALARM);
      r_beep  <= (w_state_nxt == ST_EXIT_DELAY) || (w_state_nxt == ST_ENTRY_DELAY);
    end
  end

  assign state     = r_state;
  assign armed     = r_armed;
  assign siren     = r_siren;
  assign beep      = r_beep;
  assign arm_fault = r_fault;
  assign countdown = r_cnt;
  assign tripped   = r_trip;

endmodule

// File: tb/tb_alarm_zones_ctrl.sv
// tb/tb_alarm_zones_ctrl.sv - bench for alarm_zones_ctrl
// Reference model tracks timers as absolute end-cycles rather than a down-counter.
module tb_alarm_zones_ctrl;
  localparam int NZ = 4;
  localparam int EXIT_DLY = 16;
  localparam int ENTRY_DLY = 8;
  localparam int SIREN_TIME = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          inArm = 1'b0;
  logic          inDisarm = 1'b0;
  logic [NZ-1:0] inZone = '0;
  logic [NZ-1:0] inDelayed = '0;
  logic [NZ-1:0] inBypass = '0;
  logic [2:0]    state;
  logic          armed;
  logic          siren;
  logic          beep;
  logic          arm_fault;
  logic [7:0]    countdown;
  logic [NZ-1:0] tripped;

  alarm_zones_ctrl dut (
    .clk(clk), .reset(reset), .inArm(inArm), .inDisarm(inDisarm),
    .inZone(inZone), .inDelayed(inDelayed), .inBypass(inBypass),
    .state(state), .armed(armed), .siren(siren), .beep(beep),
    .arm_fault(arm_fault), .countdown(countdown), .tripped(tripped)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: mode 0..4, edge counter k, and the edge index at which a timed mode ends.
  int        m_st = 0;
  int        k = 0;
  int        m_end = 0;
  bit [NZ-1:0] m_trip = '0;
  bit        m_fault = 1'b0;
  bit        cmp_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit a, input bit d, input bit [NZ-1:0] z,
                            input bit [NZ-1:0] dl, input bit [NZ-1:0] bp);
    bit [NZ-1:0] act;
    bit inst, dly;
    k++;
    act  = z & ~bp;
    inst = |(act & ~dl);
    dly  = |(act & dl);
    m_fault = 1'b0;
    if (d) m_st = 0;
    else begin
      case (m_st)
        0: if (a) begin
             if (act == 0) begin m_st = 1; m_end = k + EXIT_DLY; m_trip = '0; end
             else m_fault = 1'b1;
           end
        1: if (k == m_end) m_st = 2;
        2: begin
             m_trip |= act;
             if (inst) begin m_st = 4; m_end = k + SIREN_TIME; end
             else if (dly) begin m_st = 3; m_end = k + ENTRY_DLY; end
           end
        3: begin
             m_trip |= act;
             if (inst || k == m_end) begin m_st = 4; m_end = k + SIREN_TIME; end
           end
        default: begin
             m_trip |= act;
             if (k == m_end) m_st = 2;
           end
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("state", int'(state), m_st);
      chk("armed", int'(armed), int'(m_st >= 2));
      chk("siren", int'(siren), int'(m_st == 4));
      chk("beep", int'(beep), int'(m_st == 1 || m_st == 3));
      chk("arm_fault", int'(arm_fault), int'(m_fault));
      chk("countdown", int'(countdown), (m_st == 1 || m_st == 3 || m_st == 4) ? m_end - k - 1 : 0);
      chk("tripped", int'(tripped), int'(m_trip));
    end
  end

  task automatic step(input bit a, input bit d, input bit [NZ-1:0] z,
                      input bit [NZ-1:0] dl, input bit [NZ-1:0] bp);
    inArm = a; inDisarm = d; inZone = z; inDelayed = dl; inBypass = bp;
    @(posedge clk);
    model_edge(a, d, z, dl, bp);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_st = 0; m_trip = '0; m_fault = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_state", int'(state), 0);
    chk("rst_cd", int'(countdown), 0);
    chk("rst_trip", int'(tripped), 0);
    cmp_en = 1'b1;

    step(1, 0, '0, '0, '0);
    chk("exit_state", int'(state), 1);
    chk("exit_cd", int'(countdown), 15);
    chk("exit_beep", int'(beep), 1);
    idle(15);
    chk("exit_last", int'(state), 1);
    idle(1);
    chk("armed_state", int'(state), 2);
    chk("armed_flag", int'(armed), 1);

    step(0, 0, 4'b0001, 4'b0001, '0);
    chk("entry_state", int'(state), 3);
    chk("entry_cd", int'(countdown), 7);
    idle(8);
    chk("alarm_state", int'(state), 4);
    chk("alarm_cd", int'(countdown), 31);
    chk("alarm_siren", int'(siren), 1);
    idle(32);
    chk("rearm_state", int'(state), 2);
    chk("rearm_siren", int'(siren), 0);
    chk("rearm_trip", int'(tripped), 1);

    step(0, 0, 4'b0001, 4'b0001, '0);
    step(0, 0, 4'b0010, 4'b0000, '0);
    chk("inst_state", int'(state), 4);
    chk("inst_trip", int'(tripped), 3);
    idle(5);
    step(1, 1, 4'b1111, '0, '0);
    chk("dis_state", int'(state), 0);
    chk("dis_siren", int'(siren), 0);
    chk("dis_trip", int'(tripped), 3);

    step(1, 0, 4'b0100, '0, '0);
    chk("rej_state", int'(state), 0);
    chk("rej_fault", int'(arm_fault), 1);
    chk("rej_trip", int'(tripped), 3);
    idle(1);
    chk("rej_pulse", int'(arm_fault), 0);
    step(1, 0, 4'b0100, '0, 4'b0100);
    chk("byp_state", int'(state), 1);
    chk("byp_trip", int'(tripped), 0);

    idle(3);
    reset = 1'b1;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_cd", int'(countdown), 0);
    chk("async_beep", int'(beep), 0);
    m_st = 0; m_trip = '0; m_fault = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;

    for (int c = 0; c < 4000; c++) begin
      bit [NZ-1:0] z, dl, bp;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        for (int b = 0; b < NZ; b++) begin
          z[b]  = ($urandom_range(0, 15) == 0);
          dl[b] = $urandom_range(0, 1) == 1;
          bp[b] = ($urandom_range(0, 3) == 0);
        end
        step($urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0, z, dl, bp);
      end
    end

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alarm_zones_ctrl.md
ALARM_ZONES_CTRL -- requirements
Module: alarm_zones_ctrl

Interface
REQ-001 Parameter N_ZONES, default 4, SHALL set the number of sensor zones (1..16).
REQ-002 Parameter EXIT_DLY, default 16, SHALL set the exit delay in clock cycles (1..2^CNT_W).
REQ-003 Parameter ENTRY_DLY, default 8, SHALL set the entry delay in clock cycles (1..2^CNT_W).
REQ-004 Parameter SIREN_TIME, default 32, SHALL set the siren-on duration in clock cycles (1..2^CNT_W).
REQ-005 Parameter CNT_W, default 8, SHALL set the countdown register width.
REQ-006 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-007 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-008 inArm  input  1  SHALL be the arm request, sampled each cycle.
REQ-009 inDisarm  input  1  SHALL be the disarm request, sampled each cycle.
REQ-010 inZone  input  N_ZONES  SHALL be the per-zone trip inputs, 1 = zone faulted.
REQ-011 inDelayed  input  N_ZONES  SHALL mark delayed zones (1 = entry-delay zone, 0 = instant zone).
REQ-012 inBypass  input  N_ZONES  SHALL mark bypassed zones (1 = ignored everywhere).
REQ-013 state  output  3  SHALL report FSM state: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4.
REQ-014 armed  output  1  SHALL be 1 in ARMED, ENTRY_DELAY and ALARM.
REQ-015 siren  output  1  SHALL be 1 only in ALARM.
REQ-016 beep  output  1  SHALL be 1 only in EXIT_DELAY and ENTRY_DELAY.
REQ-017 arm_fault  output  1  SHALL pulse one cycle when an arm request is rejected.
REQ-018 countdown  output  CNT_W  SHALL show remaining cycles of the active timer, 0 otherwise.
REQ-019 tripped  output  N_ZONES  SHALL hold the latched zone-trip memory.

Function
REQ-020 All outputs SHALL be registered; a sampled input affects outputs exactly one cycle later.
REQ-021 Effective zone fault SHALL be act[i] = inZone[i] & ~inBypass[i]; inst = OR(act & ~inDelayed); dly = OR(act & inDelayed).
REQ-022 inDisarm SHALL take priority over every other input in every state, including same-cycle inArm or zone faults; next state DISARMED, countdown 0.
REQ-023 DISARMED: inArm with act = 0 -> EXIT_DELAY, countdown = EXIT_DLY-1, tripped cleared to 0.
REQ-024 DISARMED: inArm with act != 0 -> stay DISARMED, arm_fault = 1 for one cycle, tripped unchanged.
REQ-025 EXIT_DELAY: zones ignored; countdown decrements each cycle; when countdown = 0 -> ARMED next cycle.
REQ-026 ARMED: inst = 1 -> ALARM, countdown = SIREN_TIME-1; else dly = 1 -> ENTRY_DELAY, countdown = ENTRY_DLY-1.
REQ-027 ENTRY_DELAY: inst = 1 -> ALARM immediately (countdown = SIREN_TIME-1); else decrement; at countdown = 0 -> ALARM.
REQ-028 ALARM: countdown decrements; at countdown = 0 -> ARMED (siren off, re-armed); new faults in ALARM do not restart the timer.
REQ-029 In ARMED, ENTRY_DELAY and ALARM, tripped SHALL OR-accumulate act each cycle; tripped SHALL persist through DISARMED until the next successful arm.
REQ-030 inArm SHALL be ignored in every state except DISARMED.
REQ-031 Countdown SHALL never wrap; decrement occurs only while nonzero.
REQ-032 Undefined state encodings SHALL recover to DISARMED on the next clock.

Reset
REQ-033 reset = 1 SHALL immediately force state = DISARMED and armed, siren, beep, arm_fault, countdown, tripped to 0, regardless of clk, including mid-timer.
REQ-034 After reset deasserts, the first rising edge SHALL evaluate inputs from DISARMED.

Verification
REQ-035 Defaults; inArm pulse, zones idle -> EXIT_DELAY with beep for 16 cycles, then state = 2, armed = 1.
REQ-036 Armed; inZone = 0001, inDelayed = 0001 -> ENTRY_DELAY 8 cycles, then ALARM, siren = 1 for 32 cycles, then ARMED, tripped = 0001.
REQ-037 ENTRY_DELAY active; inZone = 0010 instant -> ALARM next cycle, tripped = 0011.
REQ-038 DISARMED; inZone = 0100, inBypass = 0000, inArm -> arm_fault pulse, state stays 0; repeat with inBypass = 0100 -> EXIT_DELAY.
REQ-039 ALARM mid-siren; inArm = inDisarm = 1 same cycle -> DISARMED, siren = 0, tripped retained.
REQ-040 reset asserted mid-EXIT_DELAY between clock edges -> all outputs 0 before next clk edge.
